// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared types and sign-magnitude/two's-complement helpers
package sm_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int SM_WIDTH = 8;

  function automatic logic [63:0] sm_mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // -0 maps to +0 because the magnitude test comes before negation
  function automatic logic [63:0] sm_to_c2(input logic [63:0] v, input int w);
    logic [63:0] mag;
    logic        sgn;
    mag = v & sm_mask(w - 1);
    sgn = ((v >> (w - 1)) & 64'd1) != 64'd0;
    if (sgn && mag != 64'd0)
      return (~mag + 64'd1) & sm_mask(w);
    return mag;
  endfunction

  // the most-negative code has no magnitude, so it passes through as 100..0
  function automatic logic [63:0] c2_to_sm(input logic [63:0] v, input int w);
    logic [63:0] m;
    logic [63:0] top;
    logic [63:0] val;
    logic [63:0] neg;
    m   = sm_mask(w);
    top = 64'd1 << (w - 1);
    val = v & m;
    neg = (~val + 64'd1) & m;
    if ((val & top) == 64'd0)
      return val;
    if (neg == top)
      return val;
    return top | neg;
  endfunction

endpackage

// File: rtl/fac.sv
// rtl/fac.sv - single-bit full-adder cell
module fac (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sm_serial_sub.sv
// rtl/sm_serial_sub.sv - bit-serial sign-magnitude subtractor z = x - y
module sm_serial_sub
  import sm_pkg::*;
#(
  parameter int WIDTH = SM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             c_out,
  output logic             ovr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] xa;
  logic [WIDTH-1:0] yb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             x_msb;
  logic             y_msb;
  logic [WIDTH-1:0] x_c2;
  logic [WIDTH-1:0] y_c2;
  logic             sum;
  logic             co;

  assign x_c2 = WIDTH'(sm_to_c2(64'(x), WIDTH));
  assign y_c2 = WIDTH'(sm_to_c2(64'(y), WIDTH));

  fac u_fac (
    .a  (xa[0]),
    .b  (yb[0]),
    .ci (carry),
    .s  (sum),
    .co (co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      xa    <= '0;
      yb    <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      c_out <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xa    <= x_c2;
            yb    <= ~y_c2;
            x_msb <= x_c2[WIDTH-1];
            y_msb <= y_c2[WIDTH-1];
            carry <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res   <= {sum, res[WIDTH-1:1]};
          xa    <= xa >> 1;
          yb    <= yb >> 1;
          carry <= co;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // x - y overflows when the two's-complement operands differ in sign
          // and the result sign departs from the minuend's
          z     <= WIDTH'(c2_to_sm(64'(res), WIDTH));
          ovr   <= ((x_msb != y_msb) && (res[WIDTH-1] != x_msb)) || (res == MOST_NEG);
          c_out <= carry;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_serial_sub.sv
// tb/tb_sm_serial_sub.sv - scoreboard testbench for sm_serial_sub
module tb_sm_serial_sub;

  typedef struct packed {
    logic [7:0] z;
    logic       c;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       busy;
  logic       done;
  logic [7:0] z;
  logic       c_out;
  logic       ovr;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sm_serial_sub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .c_out (c_out),
    .ovr   (ovr)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // integer reference: subtract real values, then wrap into 8 bits
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int av, bv, diff, wrapped, s;
    av = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
    bv = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    diff = av - bv;
    s = (av & 255) + ((~bv) & 255) + 1;
    e.c = s[8];
    e.o = (diff > 127) || (diff < -127);
    wrapped = diff & 255;
    if (!e.o)
      e.z = (diff < 0) ? 8'(128 | (-diff)) : 8'(diff);
    else if (wrapped == 128)
      e.z = 8'h80;
    else if (wrapped >= 128)
      e.z = 8'(128 | ((256 - wrapped) & 127));
    else
      e.z = 8'(wrapped);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("z", z, e.z);
        check_val("c_out", c_out, e.c);
        check_val("ovr", ovr, e.o);
      end
    end
  end

  task automatic run_op(input logic [7:0] xi, input logic [7:0] yi, input logic [7:0] poke_x,
                        input bit pulse_mid);
    int lat, bcnt;
    sb.push_back(model(xi, yi));
    @(negedge clk);
    x = xi; y = yi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = poke_x; y = 8'($urandom);
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      if (busy) bcnt++;
      if (pulse_mid && i == 3) begin
        start = 1'b1; x = 8'h7F; y = 8'h01;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) lat = i;
    end
    check_val("latency", lat, 9);
    check_val("busy_cycles", bcnt, 8);
  endtask

  initial begin
    int dcnt;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_z", z, 0);
    check_val("rst_c_out", c_out, 0);
    check_val("rst_ovr", ovr, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h05, 8'h03, 8'hAA, 1'b0);
    run_op(8'h03, 8'h05, 8'h55, 1'b0);
    run_op(8'h64, 8'hE4, 8'h00, 1'b0);
    run_op(8'hC0, 8'h40, 8'hFF, 1'b0);
    run_op(8'h80, 8'h00, 8'h12, 1'b0);
    run_op(8'h7F, 8'h81, 8'h34, 1'b0);
    run_op(8'h00, 8'h80, 8'h56, 1'b0);
    run_op(8'hFF, 8'hFF, 8'h78, 1'b0);
    for (int k = 0; k < 16; k++)
      run_op(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);

    // a start pulse during SHIFT must not disturb or queue anything
    run_op(8'h05, 8'h03, 8'h00, 1'b1);
    repeat (12) @(negedge clk);

    // reset at SHIFT bit 4 discards the operation
    @(negedge clk);
    x = 8'h64; y = 8'hE4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_z", z, 0);
    check_val("mid_rst_c_out", c_out, 0);
    check_val("mid_rst_ovr", ovr, 0);
    check_val("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check_val("no_done_after_rst", dcnt, 0);

    run_op(8'h05, 8'h03, 8'h99, 1'b0);
    repeat (3) @(negedge clk);
    check_val("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
